motion_sequencer: RTL and testbench

//  Consumes decoded motion commands from the command interface and sequences them into axis segments
//  and gripper actions for the SCARA joint controllers. It accepts one command at a time and runs it
//  to completion. Every segment waits for a completion from the joint controllers and has a timeout.

---
 rtl/scara_pkg.sv | 41 ++++
 rtl/motion_sequencer_if.sv | 32 +++
 rtl/seq_step_timer.sv | 36 +++
 rtl/motion_sequencer.sv | 172 +++++++++++++++++
 tb/tb_motion_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/scara_pkg.sv
// Shared codes for the SCARA motion path: command codes, segment kinds and sequencer states.
// Also provides the width helper for the step timer.
package scara_pkg;

   typedef logic [2:0] motion_cmd_t;
   typedef logic [1:0] seg_kind_t;

   localparam motion_cmd_t MC_MOVE  = 3'b000;
   localparam motion_cmd_t MC_PICK  = 3'b001;
   localparam motion_cmd_t MC_PLACE = 3'b010;
   localparam motion_cmd_t MC_HOME  = 3'b011;
   localparam motion_cmd_t MC_STOP  = 3'b100;

   localparam seg_kind_t SK_XY   = 2'b00;
   localparam seg_kind_t SK_ZDN  = 2'b01;
   localparam seg_kind_t SK_ZUP  = 2'b10;
   localparam seg_kind_t SK_HOME = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_XY_WAIT   = 3'd1,
      ST_ZDN_WAIT  = 3'd2,
      ST_GRIP_WAIT = 3'd3,
      ST_ZUP_WAIT  = 3'd4,
      ST_HOME_WAIT = 3'd5,
      ST_FAULT     = 3'd6
   } seq_state_t;

   // Codes above MC_STOP are undefined and always rejected.
   function automatic logic cmd_valid(input motion_cmd_t c);
      return c <= MC_STOP;
   endfunction

   // Counter width large enough to reach the larger of the two terminal counts.
   function automatic int ctr_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/motion_sequencer_if.sv
// Command and segment signalling between the motion sequencer, the command decoder and the joint
// controllers.
// Handshake: cmd_ack qualifies motion_cmd for one cycle and may stay high on consecutive cycles.
// There is no ready; every qualified command is accepted, ignored (STOP when idle or faulted) or
// answered with a one-cycle cmd_rej on the following cycle. seg_start, seg_abort, op_done and
// cmd_rej are single-cycle pulses; seg_done is a pulse from the joint controllers.
interface motion_sequencer_if;
   import scara_pkg::*;

   motion_cmd_t motion_cmd;
   logic        cmd_ack;
   logic        seg_done;
   logic        seg_start;
   seg_kind_t   seg_kind;
   logic        seg_abort;
   logic        grip_close;
   logic        busy;
   logic        op_done;
   logic        cmd_rej;
   logic        fault;

   modport slave (
      input  motion_cmd, cmd_ack, seg_done,
      output seg_start, seg_kind, seg_abort, grip_close, busy, op_done, cmd_rej, fault
   );

   modport master (
      output motion_cmd, cmd_ack, seg_done,
      input  seg_start, seg_kind, seg_abort, grip_close, busy, op_done, cmd_rej, fault
   );

endinterface

// File: rtl/seq_step_timer.sv
// Saturating step counter shared by the segment timeout and the gripper settle delay.
// Flags fire when the count sits on the last cycle of either interval.
module seq_step_timer
   import scara_pkg::*;
#(
   parameter  int TIMEOUT_CYC = 1_000_000,
   parameter  int GRIP_CYC    = 50_000,
   localparam int CW          = ctr_width(TIMEOUT_CYC, GRIP_CYC)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          enable,
   output logic [CW-1:0] count,
   output logic          at_timeout,
   output logic          at_grip
);

   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] GRIP_LAST = CW'(GRIP_CYC - 1);

   // Holds at all-ones rather than wrapping back into a live window.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + CW'(1);
      end
   end

   assign at_timeout = (count == TO_LAST);
   assign at_grip    = (count == GRIP_LAST);

endmodule

// File: rtl/motion_sequencer.sv
// Runs one decoded motion command at a time as a chain of joint segments and gripper actions,
// with a per-segment timeout that latches a fault only HOME can clear.
module motion_sequencer
   import scara_pkg::*;
#(
   parameter  int TIMEOUT_CYC = 1_000_000,
   parameter  int GRIP_CYC    = 50_000,
   localparam int CW          = ctr_width(TIMEOUT_CYC, GRIP_CYC)
) (
   input  logic                clock,
   input  logic                reset,
   motion_sequencer_if.slave   bus,
   output seq_state_t          dbg_state,
   output logic [CW-1:0]       dbg_count
);

   seq_state_t    state, state_nxt;
   logic          seg_start_q, seg_start_nxt;
   seg_kind_t     seg_kind_q, seg_kind_nxt;
   logic          seg_abort_q, seg_abort_nxt;
   logic          grip_q, grip_nxt;
   logic          op_done_q, op_done_nxt;
   logic          cmd_rej_q, cmd_rej_nxt;
   logic          fault_q, fault_nxt;
   logic          op_is_pick, op_is_pick_nxt;

   logic          busy;
   logic          is_stop;
   logic          done_ok;
   logic          tmr_clear;
   logic          at_timeout;
   logic          at_grip;
   logic [CW-1:0] count;

   assign busy    = (state != ST_IDLE) && (state != ST_FAULT);
   assign is_stop = bus.cmd_ack && (bus.motion_cmd == MC_STOP);
   // seg_done on the seg_start cycle belongs to the previous segment, so it is discarded.
   assign done_ok = bus.seg_done && !seg_start_q;
   assign tmr_clear = (state_nxt != state) || !busy;

   seq_step_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .GRIP_CYC    (GRIP_CYC)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .clear      (tmr_clear),
      .enable     (busy),
      .count      (count),
      .at_timeout (at_timeout),
      .at_grip    (at_grip)
   );

   always_comb begin
      state_nxt      = state;
      seg_start_nxt  = 1'b0;
      seg_kind_nxt   = seg_kind_q;
      seg_abort_nxt  = 1'b0;
      grip_nxt       = grip_q;
      op_done_nxt    = 1'b0;
      cmd_rej_nxt    = bus.cmd_ack && !cmd_valid(bus.motion_cmd);
      fault_nxt      = fault_q;
      op_is_pick_nxt = op_is_pick;

      case (state)
         ST_IDLE: begin
            if (bus.cmd_ack) begin
               case (bus.motion_cmd)
                  MC_MOVE: begin
                     state_nxt     = ST_XY_WAIT;
                     seg_start_nxt = 1'b1;
                     seg_kind_nxt  = SK_XY;
                  end
                  MC_PICK, MC_PLACE: begin
                     state_nxt      = ST_ZDN_WAIT;
                     seg_start_nxt  = 1'b1;
                     seg_kind_nxt   = SK_ZDN;
                     op_is_pick_nxt = (bus.motion_cmd == MC_PICK);
                  end
                  MC_HOME: begin
                     state_nxt     = ST_HOME_WAIT;
                     seg_start_nxt = 1'b1;
                     seg_kind_nxt  = SK_HOME;
                  end
                  default: ;
               endcase
            end
         end

         ST_FAULT: begin
            if (bus.cmd_ack) begin
               if (bus.motion_cmd == MC_HOME) begin
                  state_nxt     = ST_HOME_WAIT;
                  seg_start_nxt = 1'b1;
                  seg_kind_nxt  = SK_HOME;
                  fault_nxt     = 1'b0;
               end else if (bus.motion_cmd != MC_STOP) begin
                  cmd_rej_nxt = 1'b1;
               end
            end
         end

         default: begin
            // STOP outranks both a completion and a timeout landing on the same cycle.
            if (is_stop) begin
               state_nxt     = ST_IDLE;
               seg_abort_nxt = 1'b1;
            end else begin
               if (bus.cmd_ack) begin
                  cmd_rej_nxt = 1'b1;
               end
               if (state == ST_GRIP_WAIT) begin
                  if (at_grip) begin
                     state_nxt     = ST_ZUP_WAIT;
                     seg_start_nxt = 1'b1;
                     seg_kind_nxt  = SK_ZUP;
                  end
               end else if (done_ok) begin
                  if (state == ST_ZDN_WAIT) begin
                     state_nxt = ST_GRIP_WAIT;
                     grip_nxt  = op_is_pick;
                  end else begin
                     state_nxt   = ST_IDLE;
                     op_done_nxt = 1'b1;
                  end
               end else if (at_timeout) begin
                  state_nxt     = ST_FAULT;
                  fault_nxt     = 1'b1;
                  seg_abort_nxt = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         seg_start_q <= 1'b0;
         seg_kind_q  <= SK_XY;
         seg_abort_q <= 1'b0;
         grip_q      <= 1'b0;
         op_done_q   <= 1'b0;
         cmd_rej_q   <= 1'b0;
         fault_q     <= 1'b0;
         op_is_pick  <= 1'b0;
      end else begin
         state       <= state_nxt;
         seg_start_q <= seg_start_nxt;
         seg_kind_q  <= seg_kind_nxt;
         seg_abort_q <= seg_abort_nxt;
         grip_q      <= grip_nxt;
         op_done_q   <= op_done_nxt;
         cmd_rej_q   <= cmd_rej_nxt;
         fault_q     <= fault_nxt;
         op_is_pick  <= op_is_pick_nxt;
      end
   end

   assign bus.seg_start  = seg_start_q;
   assign bus.seg_kind   = seg_kind_q;
   assign bus.seg_abort  = seg_abort_q;
   assign bus.grip_close = grip_q;
   assign bus.busy       = busy;
   assign bus.op_done    = op_done_q;
   assign bus.cmd_rej    = cmd_rej_q;
   assign bus.fault      = fault_q;

   assign dbg_state = state;
   assign dbg_count = count;

endmodule

// File: tb/tb_motion_sequencer.sv
// Bench for motion_sequencer with TIMEOUT_CYC = 20 and GRIP_CYC = 4.
// Output word: {seg_start, seg_kind[1:0], seg_abort, grip_close, busy, op_done, cmd_rej, fault}.
module tb_motion_sequencer;
   import scara_pkg::*;

   localparam int TO = 20;
   localparam int GC = 4;
   localparam int CW = ctr_width(TO, GC);
   localparam int W  = 9;

   typedef struct packed {
      logic          rst;
      logic          ack;
      logic [2:0]    cmd;
      logic          done;
      logic [W-1:0]  exp;
   } vec_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   seq_state_t    dbg_state;
   logic [CW-1:0] dbg_count;
   int            checks = 0;
   int            failures = 0;
   logic [W-1:0]  exp_q[$];
   vec_t          vecs[$];

   motion_sequencer_if bus();

   motion_sequencer #(
      .TIMEOUT_CYC (TO),
      .GRIP_CYC    (GC)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state),
      .dbg_count (dbg_count)
   );

   always #5 clock = ~clock;

   task automatic add(input logic rst, input logic ack, input logic [2:0] cmd,
                      input logic done, input logic [W-1:0] e);
      vec_t v;
      v.rst  = rst;
      v.ack  = ack;
      v.cmd  = cmd;
      v.done = done;
      v.exp  = e;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, queue the expected next-cycle outputs, then compare after the edge.
   task automatic cyc(input logic rst, input logic ack, input logic [2:0] cmd, input logic done,
                      input logic [W-1:0] e, input string tag);
      logic [W-1:0] got;
      logic [W-1:0] want;
      reset          = rst;
      bus.cmd_ack    = ack;
      bus.motion_cmd = cmd;
      bus.seg_done   = done;
      exp_q.push_back(e);
      @(posedge clock);
      @(negedge clock);
      got = {bus.seg_start, bus.seg_kind, bus.seg_abort, bus.grip_close,
             bus.busy, bus.op_done, bus.cmd_rej, bus.fault};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %b expected %b", tag, got, want);
      end
   endtask

   task automatic idle(input int n, input logic [W-1:0] e, input string tag);
      for (int k = 0; k < n; k++) begin
         cyc(1'b0, 1'b0, MC_MOVE, 1'b0, e, tag);
      end
   endtask

   task automatic check_state(input string tag, input seq_state_t e);
      checks++;
      if (dbg_state !== e) begin
         failures++;
         $display("FAIL %s: state got %0d expected %0d", tag, dbg_state, e);
      end
   endtask

   task automatic check_count(input string tag, input logic [CW-1:0] e);
      checks++;
      if (dbg_count !== e) begin
         failures++;
         $display("FAIL %s: count got %0d expected %0d", tag, dbg_count, e);
      end
   endtask

   initial begin
      int n;
      logic [2:0] bad;

      bus.cmd_ack    = 1'b0;
      bus.motion_cmd = MC_MOVE;
      bus.seg_done   = 1'b0;

      // Reset, including a command and seg_done presented while reset is high
      add(1'b1, 1'b0, MC_MOVE,  1'b0, 9'b0_00_0_0_0_0_0_0);
      add(1'b1, 1'b1, MC_PICK,  1'b1, 9'b0_00_0_0_0_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_00_0_0_0_0_0_0);
      // MOVE: start next cycle, busy through the done cycle, op_done after
      add(1'b0, 1'b1, MC_MOVE,  1'b0, 9'b1_00_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_00_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_00_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_00_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_00_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b1, 9'b0_00_0_0_0_1_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_00_0_0_0_0_0_0);
      // seg_done on the seg_start cycle is ignored
      add(1'b0, 1'b1, MC_MOVE,  1'b0, 9'b1_00_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b1, 9'b0_00_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b1, 9'b0_00_0_0_0_1_0_0);
      // invalid code in IDLE is rejected; STOP in IDLE does nothing
      add(1'b0, 1'b1, 3'b111,   1'b0, 9'b0_00_0_0_0_0_1_0);
      add(1'b0, 1'b1, MC_STOP,  1'b0, 9'b0_00_0_0_0_0_0_0);
      // commands while busy are rejected; back-to-back on the completion edge too
      add(1'b0, 1'b1, MC_MOVE,  1'b0, 9'b1_00_0_0_1_0_0_0);
      add(1'b0, 1'b1, MC_MOVE,  1'b0, 9'b0_00_0_0_1_0_1_0);
      add(1'b0, 1'b1, 3'b101,   1'b0, 9'b0_00_0_0_1_0_1_0);
      add(1'b0, 1'b1, MC_HOME,  1'b0, 9'b0_00_0_0_1_0_1_0);
      add(1'b0, 1'b1, MC_MOVE,  1'b1, 9'b0_00_0_0_0_1_1_0);
      add(1'b0, 1'b1, MC_MOVE,  1'b0, 9'b1_00_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_00_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b1, 9'b0_00_0_0_0_1_0_0);
      // PICK: Z_DOWN, four gripper cycles (seg_done ignored there), Z_UP, gripper stays closed
      add(1'b0, 1'b1, MC_PICK,  1'b0, 9'b1_01_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_01_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b1, 9'b0_01_0_1_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b1, 9'b0_01_0_1_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_01_0_1_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_01_0_1_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b1_10_0_1_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_10_0_1_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b1, 9'b0_10_0_1_0_1_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_10_0_1_0_0_0_0);
      // PLACE aborted by STOP during Z_DOWN: gripper untouched
      add(1'b0, 1'b1, MC_PLACE, 1'b0, 9'b1_01_0_1_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_01_0_1_1_0_0_0);
      add(1'b0, 1'b1, MC_STOP,  1'b0, 9'b0_01_1_1_0_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_01_0_1_0_0_0_0);
      // PLACE opens the gripper; STOP with seg_done in Z_UP gives no op_done
      add(1'b0, 1'b1, MC_PLACE, 1'b0, 9'b1_01_0_1_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b1, 9'b0_01_0_1_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b1, 9'b0_01_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_01_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_01_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_01_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b1_10_0_0_1_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_10_0_0_1_0_0_0);
      add(1'b0, 1'b1, MC_STOP,  1'b1, 9'b0_10_1_0_0_0_0_0);
      add(1'b0, 1'b0, MC_MOVE,  1'b0, 9'b0_10_0_0_0_0_0_0);

      @(negedge clock);
      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].rst, vecs[i].ack, vecs[i].cmd, vecs[i].done, vecs[i].exp,
             $sformatf("vec%0d", i));
      end

      // MOVE with a random completion delay inside the timeout window
      n = $urandom_range(1, 18);
      cyc(1'b0, 1'b1, MC_MOVE, 1'b0, 9'b1_00_0_0_1_0_0_0, "rand_move_start");
      idle(n, 9'b0_00_0_0_1_0_0_0, "rand_move_busy");
      cyc(1'b0, 1'b0, MC_MOVE, 1'b1, 9'b0_00_0_0_0_1_0_0, "rand_move_done");

      // Timeout: fault and seg_abort twenty cycles after seg_start
      cyc(1'b0, 1'b1, MC_MOVE, 1'b0, 9'b1_00_0_0_1_0_0_0, "to_start");
      idle(TO - 1, 9'b0_00_0_0_1_0_0_0, "to_busy");
      idle(1, 9'b0_00_1_0_0_0_0_1, "to_fault");
      check_state("to_state", ST_FAULT);
      idle(1, 9'b0_00_0_0_0_0_0_1, "fault_hold");
      cyc(1'b0, 1'b0, MC_MOVE, 1'b1, 9'b0_00_0_0_0_0_0_1, "fault_done_ignored");
      cyc(1'b0, 1'b1, MC_PICK, 1'b0, 9'b0_00_0_0_0_0_1_1, "fault_pick_rej");
      cyc(1'b0, 1'b1, MC_STOP, 1'b0, 9'b0_00_0_0_0_0_0_1, "fault_stop_ignored");
      bad = 3'($urandom_range(5, 7));
      cyc(1'b0, 1'b1, bad, 1'b0, 9'b0_00_0_0_0_0_1_1, "fault_invalid_rej");
      cyc(1'b0, 1'b1, MC_HOME, 1'b0, 9'b1_11_0_0_1_0_0_0, "fault_home");
      idle(1, 9'b0_11_0_0_1_0_0_0, "home_busy");
      cyc(1'b0, 1'b0, MC_MOVE, 1'b1, 9'b0_11_0_0_0_1_0_0, "home_done");

      // seg_done on the last timeout cycle wins over the timeout
      cyc(1'b0, 1'b1, MC_MOVE, 1'b0, 9'b1_00_0_0_1_0_0_0, "race_done_start");
      idle(TO - 1, 9'b0_00_0_0_1_0_0_0, "race_done_busy");
      cyc(1'b0, 1'b0, MC_MOVE, 1'b1, 9'b0_00_0_0_0_1_0_0, "race_done_wins");

      // STOP on the last timeout cycle wins over the timeout
      cyc(1'b0, 1'b1, MC_MOVE, 1'b0, 9'b1_00_0_0_1_0_0_0, "race_stop_start");
      idle(TO - 1, 9'b0_00_0_0_1_0_0_0, "race_stop_busy");
      cyc(1'b0, 1'b1, MC_STOP, 1'b0, 9'b0_00_1_0_0_0_0_0, "race_stop_wins");
      idle(1, 9'b0_00_0_0_0_0_0_0, "race_stop_nofault");

      // Reset in the middle of GRIP_WAIT clears every output on the next edge
      cyc(1'b0, 1'b1, MC_PICK, 1'b0, 9'b1_01_0_0_1_0_0_0, "rst_pick_start");
      idle(1, 9'b0_01_0_0_1_0_0_0, "rst_pick_busy");
      cyc(1'b0, 1'b0, MC_MOVE, 1'b1, 9'b0_01_0_1_1_0_0_0, "rst_grip_enter");
      idle(1, 9'b0_01_0_1_1_0_0_0, "rst_grip_hold");
      cyc(1'b1, 1'b0, MC_MOVE, 1'b0, 9'b0_00_0_0_0_0_0_0, "rst_mid_grip");
      check_state("rst_state", ST_IDLE);
      check_count("rst_count", '0);
      idle(1, 9'b0_00_0_0_0_0_0_0, "rst_release");

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
